// File: rtl/int_entry_sequencer.sv
// Interrupt entry sequencer: drains the pipeline, pushes PC/flags, fetches the ISR vector, commits.
// Optional build macro INT_SEQ_PENDING_EN keeps one request that arrives while a sequence is in flight.
module int_entry_sequencer #(
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter logic [31:0] VECTOR_ADDR  = 32'h0000_0000,
    parameter int unsigned CCR_W        = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             INT_IN,
    input  logic             Stall,
    input  logic [31:0]      PC_IN,
    input  logic [CCR_W-1:0] CCR_IN,
    input  logic [31:0]      SP_IN,
    input  logic [15:0]      MEM_RD_DATA,
    output logic             BUSY,
    output logic             MEM_WR,
    output logic             MEM_RD,
    output logic [31:0]      MEM_ADDR,
    output logic [15:0]      MEM_WR_DATA,
    output logic [31:0]      PC_OUT,
    output logic             PC_WE,
    output logic [31:0]      SP_OUT,
    output logic             SP_WE,
    output logic             CCR_CLR,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        IDLE, DRAIN, PUSH_PC_L, PUSH_PC_H, PUSH_CCR, VEC_LO, VEC_HI, COMMIT
    } state_e;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      sp_q, sp_d;
    logic [CCR_W-1:0] ccr_q, ccr_d;
    logic [15:0]      vec_lo_q, vec_lo_d;
    logic [15:0]      vec_hi_q, vec_hi_d;
    logic [15:0]      ccr_ext;
    logic             pending_q;
    logic             request;

    assign dbg_state = state_q;
    assign request   = INT_IN | pending_q;

`ifdef INT_SEQ_PENDING_EN
    logic pending_d;

    // A set flag is always consumed by the IDLE cycle it is seen in.
    always_comb begin
        pending_d = pending_q;
        if (state_q == IDLE) begin
            pending_d = 1'b0;
        end else if (INT_IN) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
        end
    end
`else
    assign pending_q = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pc_q     <= '0;
            sp_q     <= '0;
            ccr_q    <= '0;
            vec_lo_q <= '0;
            vec_hi_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pc_q     <= pc_d;
            sp_q     <= sp_d;
            ccr_q    <= ccr_d;
            vec_lo_q <= vec_lo_d;
            vec_hi_q <= vec_hi_d;
        end
    end

    // Stall freezes every non-IDLE step; a step advances only on an unstalled cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pc_d     = pc_q;
        sp_d     = sp_q;
        ccr_d    = ccr_q;
        vec_lo_d = vec_lo_q;
        vec_hi_d = vec_hi_q;
        case (state_q)
            IDLE: begin
                if (request) begin
                    pc_d    = PC_IN;
                    ccr_d   = CCR_IN;
                    sp_d    = SP_IN;
                    cnt_d   = DRAIN_LOAD;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!Stall) begin
                    if (cnt_q <= 4'd1) begin
                        cnt_d   = '0;
                        state_d = PUSH_PC_L;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            PUSH_PC_L: if (!Stall) state_d = PUSH_PC_H;
            PUSH_PC_H: if (!Stall) state_d = PUSH_CCR;
            PUSH_CCR:  if (!Stall) state_d = VEC_LO;
            VEC_LO: begin
                if (!Stall) begin
                    vec_lo_d = MEM_RD_DATA;
                    state_d  = VEC_HI;
                end
            end
            VEC_HI: begin
                if (!Stall) begin
                    vec_hi_d = MEM_RD_DATA;
                    state_d  = COMMIT;
                end
            end
            COMMIT:  if (!Stall) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Addresses and data depend only on state and latches, so they hold while stalled.
    always_comb begin
        ccr_ext            = '0;
        ccr_ext[CCR_W-1:0] = ccr_q;
        BUSY        = (state_q != IDLE);
        MEM_WR      = 1'b0;
        MEM_RD      = 1'b0;
        MEM_ADDR    = '0;
        MEM_WR_DATA = '0;
        PC_OUT      = '0;
        PC_WE       = 1'b0;
        SP_OUT      = '0;
        SP_WE       = 1'b0;
        CCR_CLR     = 1'b0;
        case (state_q)
            PUSH_PC_L: begin
                MEM_WR      = !Stall;
                MEM_ADDR    = sp_q;
                MEM_WR_DATA = pc_q[15:0];
            end
            PUSH_PC_H: begin
                MEM_WR      = !Stall;
                MEM_ADDR    = sp_q - 32'd1;
                MEM_WR_DATA = pc_q[31:16];
            end
            PUSH_CCR: begin
                MEM_WR      = !Stall;
                MEM_ADDR    = sp_q - 32'd2;
                MEM_WR_DATA = ccr_ext;
            end
            VEC_LO: begin
                MEM_RD   = !Stall;
                MEM_ADDR = VECTOR_ADDR;
            end
            VEC_HI: begin
                MEM_RD   = !Stall;
                MEM_ADDR = VECTOR_ADDR + 32'd1;
            end
            COMMIT: begin
                PC_OUT  = {vec_hi_q, vec_lo_q};
                PC_WE   = !Stall;
                SP_OUT  = sp_q - 32'd3;
                SP_WE   = !Stall;
                CCR_CLR = !Stall;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_int_entry_sequencer.sv
// Bench for int_entry_sequencer: step-list reference model, per-cycle output compare,
// write-order scoreboard, directed scenarios and a randomized phase.
module tb_int_entry_sequencer;

    localparam int          DRAIN = 2;
    localparam logic [31:0] VEC   = 32'h0000_0000;
    localparam int          OUT_W = 118;
    localparam logic [1:0]  K_DRAIN = 2'd0, K_WR = 2'd1, K_RD = 2'd2, K_COMMIT = 2'd3;
`ifdef INT_SEQ_PENDING_EN
    localparam bit PEND_EN = 1'b1;
`else
    localparam bit PEND_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        INT_IN = 1'b0;
    logic        Stall = 1'b0;
    logic [31:0] PC_IN = '0;
    logic [2:0]  CCR_IN = '0;
    logic [31:0] SP_IN = '0;
    logic [15:0] MEM_RD_DATA;
    logic        BUSY, MEM_WR, MEM_RD, PC_WE, SP_WE, CCR_CLR;
    logic [31:0] MEM_ADDR, PC_OUT, SP_OUT;
    logic [15:0] MEM_WR_DATA;
    logic [2:0]  dbg_state;
    logic [15:0] vlo = '0;
    logic [15:0] vhi = '0;

    int checks = 0;
    int errors = 0;
    int pc_we_cnt = 0;
    int strobe_cnt = 0;
    logic chk_en = 1'b0;

    int_entry_sequencer #(.DRAIN_CYCLES(DRAIN), .VECTOR_ADDR(VEC), .CCR_W(3)) dut (
        .clk(clk), .reset(reset), .INT_IN(INT_IN), .Stall(Stall),
        .PC_IN(PC_IN), .CCR_IN(CCR_IN), .SP_IN(SP_IN), .MEM_RD_DATA(MEM_RD_DATA),
        .BUSY(BUSY), .MEM_WR(MEM_WR), .MEM_RD(MEM_RD), .MEM_ADDR(MEM_ADDR),
        .MEM_WR_DATA(MEM_WR_DATA), .PC_OUT(PC_OUT), .PC_WE(PC_WE), .SP_OUT(SP_OUT),
        .SP_WE(SP_WE), .CCR_CLR(CCR_CLR), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // Vector memory: valid data only for a strobed read of the two vector words.
    assign MEM_RD_DATA = !MEM_RD ? 16'hBAD0 :
                         (MEM_ADDR == VEC)         ? vlo :
                         (MEM_ADDR == VEC + 32'd1) ? vhi : 16'hBAD1;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [15:0] data;
        logic [31:0] pc;
        logic [31:0] sp;
    } step_t;

    step_t       m_q[$];
    logic        m_pend = 1'b0;
    logic [47:0] exp_q[$];

    function automatic void build(input logic [31:0] pc, input logic [2:0] ccr, input logic [31:0] sp);
        step_t s;
        for (int i = 0; i < DRAIN; i++) begin
            s = '0; s.kind = K_DRAIN; m_q.push_back(s);
        end
        s = '0; s.kind = K_WR; s.addr = sp;         s.data = pc[15:0];
        m_q.push_back(s); exp_q.push_back({s.addr, s.data});
        s = '0; s.kind = K_WR; s.addr = sp - 32'd1; s.data = pc[31:16];
        m_q.push_back(s); exp_q.push_back({s.addr, s.data});
        s = '0; s.kind = K_WR; s.addr = sp - 32'd2; s.data = {13'd0, ccr};
        m_q.push_back(s); exp_q.push_back({s.addr, s.data});
        s = '0; s.kind = K_RD; s.addr = VEC;         m_q.push_back(s);
        s = '0; s.kind = K_RD; s.addr = VEC + 32'd1; m_q.push_back(s);
        s = '0; s.kind = K_COMMIT; s.pc = {vhi, vlo}; s.sp = sp - 32'd3; m_q.push_back(s);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_q.delete();
            exp_q.delete();
            m_pend = 1'b0;
        end else if (m_q.size() == 0) begin
            if (INT_IN || m_pend) begin
                build(PC_IN, CCR_IN, SP_IN);
                m_pend = 1'b0;
            end
        end else begin
            if (INT_IN && PEND_EN) m_pend = 1'b1;
            if (!Stall) void'(m_q.pop_front());
        end
    end

    function automatic logic [OUT_W-1:0] expected();
        logic busy, wr, rd, pcwe, spwe, clr;
        logic [31:0] addr, pco, spo;
        logic [15:0] wd;
        busy = 1'b0; wr = 1'b0; rd = 1'b0; pcwe = 1'b0; spwe = 1'b0; clr = 1'b0;
        addr = '0; pco = '0; spo = '0; wd = '0;
        if (reset && m_q.size() != 0) begin
            busy = 1'b1;
            case (m_q[0].kind)
                K_WR: begin wr = !Stall; addr = m_q[0].addr; wd = m_q[0].data; end
                K_RD: begin rd = !Stall; addr = m_q[0].addr; end
                K_COMMIT: begin
                    pco = m_q[0].pc; spo = m_q[0].sp;
                    pcwe = !Stall; spwe = !Stall; clr = !Stall;
                end
                default: ;
            endcase
        end
        return {busy, wr, rd, addr, wd, pco, pcwe, spo, spwe, clr};
    endfunction

    // ---------------- compare process + write scoreboard ----------------
    logic [OUT_W-1:0] got_v, exp_v;
    logic [47:0]      wr_exp;

    always @(negedge clk) begin
        if (chk_en) begin
            got_v = {BUSY, MEM_WR, MEM_RD, MEM_ADDR, MEM_WR_DATA, PC_OUT, PC_WE, SP_OUT, SP_WE, CCR_CLR};
            exp_v = expected();
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL outputs t=%0t got=%h exp=%h", $time, got_v, exp_v);
            end
            if (MEM_WR && MEM_RD) begin
                errors++;
                $display("FAIL wr_rd_overlap t=%0t got=both exp=one", $time);
            end
            if (reset && MEM_WR) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL write_order t=%0t got=%h exp=none", $time, {MEM_ADDR, MEM_WR_DATA});
                end else begin
                    wr_exp = exp_q.pop_front();
                    if ({MEM_ADDR, MEM_WR_DATA} !== wr_exp) begin
                        errors++;
                        $display("FAIL write_order t=%0t got=%h exp=%h", $time, {MEM_ADDR, MEM_WR_DATA}, wr_exp);
                    end
                end
            end
            if (PC_WE) pc_we_cnt++;
            if (PC_WE || SP_WE || CCR_CLR) strobe_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic pulse_int(input logic [31:0] pc, input logic [2:0] ccr, input logic [31:0] sp);
        PC_IN = pc; CCR_IN = ccr; SP_IN = sp;
        INT_IN = 1'b1;
        tick();
        INT_IN = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (BUSY && n < 500) begin
            tick();
            n++;
        end
        checks++;
        if (BUSY) begin
            errors++;
            $display("FAIL wait_idle got=busy exp=idle");
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int base;
        #1 reset = 1'b0;
        #1 chk_en = 1'b1;
        tick();
        lit("reset_busy", BUSY, 0);
        lit("reset_pc_out", PC_OUT, 0);
        lit("reset_sp_out", SP_OUT, 0);
        tick();
        reset = 1'b1;
        tick();

        // Basic entry
        vlo = 16'h0200; vhi = 16'h0000;
        base = pc_we_cnt;
        pulse_int(32'h0001_2345, 3'b101, 32'h0000_0FFF);
        for (int c = 1; c <= 9; c++) begin
            case (c)
                1: lit("basic_busy_c1", BUSY, 1);
                3: begin lit("basic_wr1_addr", MEM_ADDR, 32'h0FFF); lit("basic_wr1_data", MEM_WR_DATA, 16'h2345); end
                4: begin lit("basic_wr2_addr", MEM_ADDR, 32'h0FFE); lit("basic_wr2_data", MEM_WR_DATA, 16'h0001); end
                5: begin lit("basic_wr3_addr", MEM_ADDR, 32'h0FFD); lit("basic_wr3_data", MEM_WR_DATA, 16'h0005); end
                7: lit("basic_pc_we_c7", PC_WE, 0);
                8: begin
                    lit("basic_pc_we_c8", PC_WE, 1);
                    lit("basic_pc_out", PC_OUT, 32'h0000_0200);
                    lit("basic_sp_out", SP_OUT, 32'h0000_0FFC);
                    lit("basic_sp_we", SP_WE, 1);
                    lit("basic_ccr_clr", CCR_CLR, 1);
                end
                9: begin lit("basic_busy_c9", BUSY, 0); lit("basic_pc_we_c9", PC_WE, 0); end
                default: ;
            endcase
            tick();
        end
        lit("basic_pc_we_once", pc_we_cnt - base, 1);

        // Stall mid-sequence during PUSH_PC_H
        pulse_int(32'h0001_2345, 3'b101, 32'h0000_0FFF);
        for (int c = 1; c <= 11; c++) begin
            if (c == 4) Stall = 1'b1;
            if (c == 7) Stall = 1'b0;
            #1;
            if (c >= 4 && c <= 6) begin
                lit("stall_mem_wr", MEM_WR, 0);
                lit("stall_addr_hold", MEM_ADDR, 32'h0FFE);
                lit("stall_busy", BUSY, 1);
            end
            if (c == 7) lit("stall_wr_reissue", MEM_WR, 1);
            if (c == 10) lit("stall_pc_we_c10", PC_WE, 0);
            if (c == 11) lit("stall_pc_we_c11", PC_WE, 1);
            tick();
        end
        wait_idle();

        // Stalled accept in IDLE
        Stall = 1'b1;
        pulse_int(32'h0000_1111, 3'b011, 32'h0000_0800);
        for (int c = 1; c <= 11; c++) begin
            if (c == 4) Stall = 1'b0;
            #1;
            if (c == 1) lit("sacc_busy_c1", BUSY, 1);
            if (c == 3) lit("sacc_drain_hold", MEM_ADDR, 0);
            if (c == 6) begin lit("sacc_wr_c6", MEM_WR, 1); lit("sacc_addr_c6", MEM_ADDR, 32'h0800); end
            if (c == 10) lit("sacc_pc_we_c10", PC_WE, 0);
            if (c == 11) lit("sacc_pc_we_c11", PC_WE, 1);
            tick();
        end
        wait_idle();

        // Reset abort during VEC_LO
        base = strobe_cnt;
        pulse_int(32'h0000_2222, 3'b001, 32'h0000_0400);
        repeat (5) tick();
        lit("abort_rd_c6", MEM_RD, 1);
        reset = 1'b0;
        #1;
        lit("abort_busy", BUSY, 0);
        lit("abort_mem_rd", MEM_RD, 0);
        lit("abort_addr", MEM_ADDR, 0);
        tick();
        tick();
        reset = 1'b1;
        repeat (12) tick();
        lit("abort_no_commit", strobe_cnt - base, 0);
        lit("abort_idle", BUSY, 0);

        // Second request during PUSH_CCR
        base = pc_we_cnt;
        pulse_int(32'h0000_3333, 3'b110, 32'h0000_0200);
        repeat (4) tick();
        INT_IN = 1'b1;
        tick();
        INT_IN = 1'b0;
        repeat (2) tick();
        lit("req_pc_we_c8", PC_WE, 1);
        tick();
        lit("req_busy_c9", BUSY, 0);
        tick();
        lit("req_busy_c10", BUSY, 32'(PEND_EN));
        wait_idle();
        lit("req_commits", pc_we_cnt - base, PEND_EN ? 2 : 1);

        // SP wrap
        pulse_int(32'hCAFE_BEEF, 3'b010, 32'h0000_0001);
        repeat (2) tick();
        lit("wrap_addr_c3", MEM_ADDR, 32'h0000_0001);
        tick();
        lit("wrap_addr_c4", MEM_ADDR, 32'h0000_0000);
        tick();
        lit("wrap_addr_c5", MEM_ADDR, 32'hFFFF_FFFF);
        repeat (3) tick();
        lit("wrap_sp_out", SP_OUT, 32'hFFFF_FFFE);
        wait_idle();

        // Randomized phase
        for (int i = 0; i < 600; i++) begin
            INT_IN = ($urandom_range(0, 7) == 0);
            Stall  = ($urandom_range(0, 3) == 0);
            PC_IN  = $urandom;
            SP_IN  = $urandom;
            CCR_IN = 3'($urandom);
            if (m_q.size() == 0 && !m_pend && !INT_IN) begin
                vlo = 16'($urandom);
                vhi = 16'($urandom);
            end
            tick();
        end
        INT_IN = 1'b0;
        Stall  = 1'b0;
        wait_idle();
        wait_idle();
        lit("writes_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
